// File: rtl/online_ccm_pipe_pkg.sv
// Shared signed-digit encoding constants and helpers for the online CCM.
// A digit is a {pos,neg} bit pair whose value is pos - neg.
package online_ccm_pipe_pkg;

   localparam int SD_W   = 2;
   localparam int SD_POS = 1;
   localparam int SD_NEG = 0;

   function automatic int wl_out_f(input int stage, input int s1);
      return 2 * (stage + s1 + 1);
   endfunction

   function automatic logic [SD_W-1:0] sd_negate(input logic [SD_W-1:0] d);
      logic [SD_W-1:0] r;
      r         = '0;
      r[SD_POS] = d[SD_NEG];
      r[SD_NEG] = d[SD_POS];
      return r;
   endfunction

endpackage

// File: rtl/online_adder.sv
// Carry-free signed-digit adder: two N-digit operands in, N+1 digits out.
// Two full-adder levels per digit; the injected LSB transfer cancels the bias.
module online_adder
   import online_ccm_pipe_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [2*N-1:0] a,
   input  logic [2*N-1:0] b,
   input  logic           cin,
   output logic [2*N+1:0] sum
);

   logic [N:0]   h;
   logic [N:0]   c;
   logic [N-1:0] t;
   logic [N-1:0] s;

   always_comb begin
      logic pa, na, pb, nb;
      h    = '0;
      c    = '0;
      t    = '0;
      s    = '0;
      sum  = '0;
      pa   = 1'b0;
      na   = 1'b0;
      pb   = 1'b0;
      nb   = 1'b0;
      h[0] = 1'b1;
      c[0] = cin;
      for (int i = 0; i < N; i++) begin
         pa       = a[SD_W*i+SD_POS];
         na       = ~a[SD_W*i+SD_NEG];
         pb       = b[SD_W*i+SD_POS];
         t[i]     = pa ^ na ^ pb;
         h[i+1]   = (pa & na) | (pa & pb) | (na & pb);
      end
      for (int i = 0; i < N; i++) begin
         nb       = ~b[SD_W*i+SD_NEG];
         s[i]     = t[i] ^ nb ^ h[i];
         c[i+1]   = (t[i] & nb) | (t[i] & h[i]) | (nb & h[i]);
         sum[SD_W*i+SD_POS] = c[i];
         sum[SD_W*i+SD_NEG] = ~s[i];
      end
      // top digit = c[N] + h[N] - 1
      sum[SD_W*N+SD_POS] = c[N] & h[N];
      sum[SD_W*N+SD_NEG] = ~c[N] & ~h[N];
   end

endmodule

// File: rtl/online_ccm_pipe.sv
// Two-stage elastic online constant-coefficient multiplier:
// y = x*(2^S1 + 2^S2) or x*(2^S1 - 2^S2), all in signed-digit form.
module online_ccm_pipe
   import online_ccm_pipe_pkg::*;
#(
   parameter  int STAGE  = 4,
   parameter  int S1     = 4,
   parameter  int S2     = 1,
   localparam int WL     = 2 * STAGE,
   localparam int WL_OA  = 2 * (STAGE + S1),
   localparam int WL_OUT = wl_out_f(STAGE, S1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WL-1:0]     x,
   input  logic              neg,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WL_OUT-1:0] y
);

   if (S1 <= S2 || S2 < 0) begin : g_bad_shift
      $error("online_ccm_pipe: need S1 > S2 >= 0");
   end

   logic              v0;
   logic              v1;
   logic [WL-1:0]     x_r;
   logic              neg_r;
   logic [WL_OUT-1:0] y_r;

   logic [WL-1:0]     xn;
   logic [WL_OA-1:0]  a_op;
   logic [WL_OA-1:0]  b_op;
   logic [WL_OUT-1:0] sum;
   logic              take1;
   logic              accept;

   for (genvar g = 0; g < STAGE; g++) begin : g_neg
      assign xn[SD_W*g +: SD_W] = neg_r ? sd_negate(x_r[SD_W*g +: SD_W])
                                        : x_r[SD_W*g +: SD_W];
   end

   assign a_op = {x_r, {(2*S1){1'b0}}};
   assign b_op = WL_OA'(xn) << (SD_W * S2);

   online_adder #(
      .N (STAGE + S1)
   ) u_add (
      .a   (a_op),
      .b   (b_op),
      .cin (1'b0),
      .sum (sum)
   );

   assign take1     = v0 && (!v1 || out_ready);
   assign in_ready  = !rst && (!v0 || !v1 || out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = v1;
   assign y         = y_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         v0    <= 1'b0;
         x_r   <= '0;
         neg_r <= 1'b0;
      end else if (accept) begin
         v0    <= 1'b1;
         x_r   <= x;
         neg_r <= neg;
      end else if (take1) begin
         v0    <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1  <= 1'b0;
         y_r <= '0;
      end else if (take1) begin
         v1  <= 1'b1;
         y_r <= sum;
      end else if (out_ready) begin
         v1  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_online_ccm_pipe.sv
// Scoreboard bench for online_ccm_pipe: driver pushes expected products,
// monitor pops and compares on every output transfer.
module tb_online_ccm_pipe;

   localparam int STAGE  = 4;
   localparam int S1     = 4;
   localparam int S2     = 1;
   localparam int WL     = 2 * STAGE;
   localparam int WL_OUT = 2 * (STAGE + S1 + 1);
   localparam int ND_OUT = STAGE + S1 + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WL-1:0]     x;
   logic              neg;
   logic              out_valid;
   logic              out_ready;
   logic [WL_OUT-1:0] y;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   bit rnd_or = 1'b0;

   always #5 clk = ~clk;

   online_ccm_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .neg       (neg),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
   );

   function automatic int dec(input logic [WL_OUT-1:0] v, input int nd);
      int r;
      r = 0;
      for (int i = nd - 1; i >= 0; i--)
         r = r * 2 + int'(v[2*i+1]) - int'(v[2*i]);
      return r;
   endfunction

   function automatic int model(input logic [WL-1:0] xv, input logic nv);
      int k;
      k = nv ? ((1 << S1) - (1 << S2)) : ((1 << S1) + (1 << S2));
      return dec(WL_OUT'(xv), STAGE) * k;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", name, got, exp);
      end
   endtask

   task automatic send(input logic [WL-1:0] xv, input logic nv, input int ev);
      int  n;
      bit  done;
      in_valid = 1'b1;
      x        = xv;
      neg      = nv;
      n        = 0;
      done     = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(ev);
            done = 1'b1;
         end else if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready 0 exp 1");
            done = 1'b1;
         end else begin
            n++;
            @(posedge clk);
            #1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // output monitor
   initial begin
      bit                stall;
      logic [WL_OUT-1:0] prev_y;
      int                e;
      stall  = 1'b0;
      prev_y = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               chk("hold_valid", int'(out_valid), 1);
               chk("hold_y", int'(y == prev_y), 1);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out got %0d exp none",
                           dec(y, ND_OUT));
               end else begin
                  e = exp_q.pop_front();
                  chk("y_value", dec(y, ND_OUT), e);
               end
            end
            stall  = out_valid && !out_ready;
            prev_y = y;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_or) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      logic [WL-1:0] rx;
      logic          rn;
      rst       = 1'b1;
      in_valid  = 1'b0;
      x         = '0;
      neg       = 1'b0;
      out_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_y", int'(y), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;

      // directed products
      send(8'b00_00_00_10, 1'b0, 18);
      send(8'b00_00_00_10, 1'b1, 14);
      send(8'b01_01_01_01, 1'b0, -270);
      send(8'b01_01_01_01, 1'b1, -210);
      send(8'b10_01_11_00, 1'b0, 72);
      send(8'b10_01_11_00, 1'b1, 56);
      idle();
      drain();

      // back-pressure: two fill the pipe, third waits for out_ready
      out_ready = 1'b0;
      send(8'b00_00_00_10, 1'b0, 18);
      send(8'b00_00_10_00, 1'b0, 36);
      in_valid = 1'b1;
      x        = 8'b00_00_10_10;
      neg      = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_out_valid", int'(out_valid), 1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", int'(in_ready), 1);
      if (in_ready) exp_q.push_back(54);
      @(posedge clk);
      #1;
      idle();
      drain();

      // streaming with random back-pressure
      rnd_or = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rx = WL'($urandom);
         rn = 1'($urandom_range(0, 1));
         send(rx, rn, model(rx, rn));
      end
      idle();
      @(posedge clk);
      rnd_or = 1'b0;
      #1;
      out_ready = 1'b1;
      drain();

      // reset with both stages full
      out_ready = 1'b0;
      send(8'b01_01_01_01, 1'b0, -270);
      send(8'b00_00_00_10, 1'b1, 14);
      idle();
      @(negedge clk);
      chk("full_in_ready", int'(in_ready), 0);
      chk("full_out_valid", int'(out_valid), 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("mid_rst_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_y", int'(y), 0);
      chk("mid_rst_in_ready2", int'(in_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rel_in_ready", int'(in_ready), 1);
      chk("rel_out_valid", int'(out_valid), 0);
      repeat (4) @(posedge clk);
      #1;
      send(8'b00_00_10_10, 1'b1, 42);
      idle();
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
